// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
// Buffers up to DEPTH signed (A, B) operand pairs from a host, then on
// `start` clears the external MAC, streams the pairs into it one per
// cycle, waits out the MAC pipeline and returns the final accumulation.
// No arithmetic is done here: `result` is a bit-exact copy of `mac_result`.
// DEPTH must be a power of two in 2..32, MAC_LAT must be at least 1.
module mac_operand_sequencer #(
    parameter int DEPTH   = 16,
    parameter int DATA_W  = 16,
    parameter int MAC_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_W-1:0]        wr_a,
    input  logic [DATA_W-1:0]        wr_b,
    input  logic                     start,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     mac_clr_n,
    output logic [DATA_W-1:0]        mac_a,
    output logic [DATA_W-1:0]        mac_b,
    input  logic [DATA_W-1:0]        mac_result,
    output logic [DATA_W-1:0]        result,
    output logic                     result_valid
);

    localparam int AW = $clog2(DEPTH);        // buffer address width
    localparam int CW = AW + 1;               // pair count width (0..DEPTH)
    localparam int DW = $clog2(MAC_LAT + 1);  // drain counter width

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [DW-1:0] MAC_LAT_C = DW'(MAC_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_reg,    state_next;
    logic [CW-1:0]       count_reg,    count_next;
    logic [CW-1:0]       rd_idx_reg,   rd_idx_next;
    logic [DW-1:0]       drain_reg,    drain_next;
    logic [DATA_W-1:0]   mac_a_reg,    mac_a_next;
    logic [DATA_W-1:0]   mac_b_reg,    mac_b_next;
    logic                mac_clr_n_reg, mac_clr_n_next;
    logic [DATA_W-1:0]   result_reg,   result_next;

    logic                wr_accept;

    // Lane 0 carries operand A, lane 1 operand B; both share one address.
    logic [DATA_W-1:0]   lane_wr [2];
    logic [DATA_W-1:0]   lane_rd [2];

    assign lane_wr[0] = wr_a;
    assign lane_wr[1] = wr_b;

    // Host writes land only while idle and while there is room.
    assign wr_ready  = (state_reg == S_IDLE) && (count_reg < DEPTH_C);
    assign wr_accept = wr_valid && wr_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [DATA_W-1:0] mem [DEPTH];

            // Operand storage: written at the current fill index, no reset needed.
            always_ff @(posedge clk) begin
                if (wr_accept) begin
                    mem[count_reg[AW-1:0]] <= lane_wr[gi];
                end
            end

            assign lane_rd[gi] = mem[rd_idx_reg[AW-1:0]];
        end
    endgenerate

    // Next-state and datapath decisions; operands default to zero so the
    // MAC only ever sees buffered data during the stream phase.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        rd_idx_next = rd_idx_reg;
        drain_next  = drain_reg;
        mac_a_next  = '0;
        mac_b_next  = '0;
        result_next = result_reg;

        case (state_reg)
            S_IDLE: begin
                rd_idx_next = '0;
                if (wr_accept) begin
                    count_next = count_reg + CW'(1);
                end
                // A pair written in the same cycle as start joins the run.
                if (start && (count_next != '0)) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // The MAC is held in reset this cycle; pair 0 is presented
                // on the edge that releases it.
                mac_a_next  = lane_rd[0];
                mac_b_next  = lane_rd[1];
                rd_idx_next = rd_idx_reg + CW'(1);
                state_next  = S_STREAM;
            end
            S_STREAM: begin
                if (rd_idx_reg == count_reg) begin
                    drain_next = MAC_LAT_C;
                    state_next = S_DRAIN;
                end else begin
                    mac_a_next  = lane_rd[0];
                    mac_b_next  = lane_rd[1];
                    rd_idx_next = rd_idx_reg + CW'(1);
                end
            end
            S_DRAIN: begin
                // Zero operands add an exact zero product while the MAC
                // pipeline empties.
                if (drain_reg == DW'(1)) begin
                    result_next = mac_result;
                    state_next  = S_DONE;
                end else begin
                    drain_next = drain_reg - DW'(1);
                end
            end
            S_DONE: begin
                count_next = '0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        mac_clr_n_next = (state_next != S_CLEAR);
    end

    // State and datapath registers; reset returns everything to idle with
    // the MAC held cleared and the buffer discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            count_reg     <= '0;
            rd_idx_reg    <= '0;
            drain_reg     <= '0;
            mac_a_reg     <= '0;
            mac_b_reg     <= '0;
            mac_clr_n_reg <= 1'b0;
            result_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            rd_idx_reg    <= rd_idx_next;
            drain_reg     <= drain_next;
            mac_a_reg     <= mac_a_next;
            mac_b_reg     <= mac_b_next;
            mac_clr_n_reg <= mac_clr_n_next;
            result_reg    <= result_next;
        end
    end

    assign busy         = (state_reg != S_IDLE);
    assign count        = count_reg;
    assign mac_clr_n    = mac_clr_n_reg;
    assign mac_a        = mac_a_reg;
    assign mac_b        = mac_b_reg;
    assign result       = result_reg;
    assign result_valid = (state_reg == S_DONE);

endmodule
